decryption_core: RTL and testbench

- Iterative AES inverse cipher (FIPS-197 §5.3) that decrypts one 128-bit block per transaction, processing one round per clock.
- It is the decrypt-side counterpart of the encryption round datapath.
- Ciphertext enters through a valid/ready handshake; plaintext leaves through a second valid/ready handshake.
- Round keys come from an external key store that this block addresses by round index.

---
 rtl/decryption_core_if.sv | 24 ++
 rtl/decryption_core.sv | 148 ++++++++++++++
 tb/tb_decryption_core.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decryption_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decryption_core_if : ciphertext-in / plaintext-out valid/ready bundle    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface decryption_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface
`default_nettype wire

// File: rtl/decryption_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decryption_core : iterative AES inverse cipher, one round per clock      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module decryption_core #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  decryption_core_if.slave        bus,
  output logic [3:0]              key_idx,
  input  logic [0:127]            round_key_in,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] RND_INIT = 4'(NR - 1);

  // Byte k of the table sits at bits 8k..8k+7
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
    $error("decryption_core: NR must be 10, 12 or 14");
  end

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e assembled from the x2/x4/x8 chain
  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [0:31] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
    end
    return res;
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [0:127] w_sb;
  logic [0:127] w_ark;
  logic [0:127] w_mix;

  // Byte r+4c of the output row r comes from column (c-r) mod 4 of the input
  genvar r, c;
  for (r = 0; r < 4; r++) begin : g_row
    for (c = 0; c < 4; c++) begin : g_col
      assign w_sb[8*(r + 4*c) +: 8] = inv_sbox(state_q[8*(r + 4*((c + 4 - r) % 4)) +: 8]);
    end
  end

  assign w_ark = w_sb ^ round_key_in;

  for (c = 0; c < 4; c++) begin : g_mix
    assign w_mix[32*c +: 32] = inv_mix_col(w_ark[32*c +: 32]);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    key_idx = 4'd0;
    case (fsm_q)
      S_IDLE: begin
        key_idx = NR_IDX;
        if (bus.in_valid) begin
          state_d = bus.data_in ^ round_key_in;
          rnd_d   = RND_INIT;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        key_idx = rnd_q;
        state_d = w_mix;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        state_d = w_ark;
        fsm_d   = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.in_ready  = (fsm_q == S_IDLE);
  assign bus.out_valid = (fsm_q == S_DONE);
  assign bus.data_out  = state_q;
  assign busy          = (fsm_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decryption_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decryption_core : directed FIPS-197 vectors with queue scoreboard     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_decryption_core;
  localparam int NR = 10;

  localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decryption_core_if bus ();
  logic [3:0]   key_idx;
  logic [0:127] round_key_in;
  logic         busy;
  logic [0:127] rk_a [0:15];
  logic [0:127] rk_b [0:15];
  logic         key_sel;

  assign round_key_in = key_sel ? rk_b[key_idx] : rk_a[key_idx];

  decryption_core #(.NR(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .key_idx      (key_idx),
    .round_key_in (round_key_in),
    .busy         (busy)
  );

  typedef struct packed {
    logic [0:127] pt;
    int           acc;
  } exp_t;

  exp_t         exp_q [$];
  int           acc_log [$];
  logic [0:127] exp_next;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic         prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or unexpected event at cycle %0d", name, cyc);
  endtask

  // Reference key schedule built from the forward S-box derived in GF(2^8)
  function automatic logic [7:0] gx(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = gx(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [0:127] key, input bit sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])} ^ {rc, 24'h0};
        rc = gx(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      logic [0:127] k;
      k = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
      if (sel) rk_b[r] = k;
      else     rk_a[r] = k;
    end
  endtask

  // Accept side: every handshake pushes the plaintext the driver intended
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back('{pt: exp_next, acc: cyc + 1});
      acc_log.push_back(cyc + 1);
    end
  end

  // Output side: latency on the rising edge of out_valid, data on handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else check("latency", 128'(cyc - exp_q[0].acc), 128'(NR));
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        check("plaintext", bus.data_out, exp_q[0].pt);
        void'(exp_q.pop_front());
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:127] ct, input logic [0:127] pt, input bit chk_key);
    int n = 0;
    tick();
    bus.in_valid = 1'b1;
    bus.data_in  = ct;
    exp_next     = pt;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) fail("send_timeout");
    if (chk_key) check("key_idx_accept", 128'(key_idx), 128'(NR));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 60);
    if (!bus.out_valid) fail("out_valid_timeout");
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (acc_log.size() < target && n < 80);
    if (acc_log.size() < target) fail("accept_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  initial begin
    int base;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    key_sel       = 1'b0;
    exp_next      = '0;
    expand(K1, 1'b0);
    expand(K2, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready",  128'(bus.in_ready),  128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy",      128'(busy),          128'(0));
    check("rst_data_out",  bus.data_out,        128'(0));
    check("rst_key_idx",   128'(key_idx),       128'(NR));

    // C.1 vector with a key_idx trace through every round
    send(CT1, PT1, 1'b1);
    for (int i = 1; i <= NR; i++) begin
      @(negedge clk);
      check("key_idx_trace", 128'(key_idx), 128'((i < NR) ? NR - i : 0));
      check("busy_in_round", 128'(busy), 128'(1));
    end
    @(negedge clk);
    check("out_valid_high", 128'(bus.out_valid), 128'(1));
    @(negedge clk);
    check("out_valid_one_cycle", 128'(bus.out_valid), 128'(0));
    check("in_ready_after_done", 128'(bus.in_ready),  128'(1));

    // Back-pressure in DONE
    bus.out_ready = 1'b0;
    send(CT1, PT1, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(bus.out_valid), 128'(1));
      check("bp_data_out",  bus.data_out,        PT1);
      check("bp_in_ready",  128'(bus.in_ready),  128'(0));
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  128'(bus.in_ready),  128'(1));
    check("bp_release_out_valid", 128'(bus.out_valid), 128'(0));

    // in_valid held with a second ciphertext during ROUND
    base = acc_log.size();
    tick();
    bus.in_valid = 1'b1;
    bus.data_in  = CT1;
    exp_next     = PT1;
    wait_acc(base + 1);
    tick();
    bus.data_in = CT2;
    exp_next    = PT2;
    wait_out();
    key_sel = 1'b1;
    wait_acc(base + 2);
    tick();
    bus.in_valid = 1'b0;
    if (acc_log.size() >= base + 2)
      check("ignored_accept_spacing", 128'(acc_log[base+1] - acc_log[base]), 128'(NR + 2));
    drain();
    key_sel = 1'b0;

    // Reset in the middle of ROUND with rnd=5
    send(CT1, PT1, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("rnd5_key_idx", 128'(key_idx), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready",  128'(bus.in_ready),  128'(1));
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_data_out",  bus.data_out,        128'(0));
    check("midrst_busy",      128'(busy),          128'(0));
    send(CT1, PT1, 1'b0);
    drain();

    // Back-to-back blocks with in_valid held high
    base = acc_log.size();
    tick();
    bus.in_valid = 1'b1;
    bus.data_in  = CT1;
    exp_next     = PT1;
    wait_acc(base + 2);
    tick();
    bus.in_valid = 1'b0;
    if (acc_log.size() >= base + 2)
      check("b2b_accept_spacing", 128'(acc_log[base+1] - acc_log[base]), 128'(NR + 2));
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
